// File: rtl/vga_scan_timer.sv
// vga_scan_timer: raster scan generator producing DrawX/DrawY and VGA DAC sync/blank/clock.
//   Clk          in   system clock (50 MHz)
//   Reset_n      in   asynchronous active-low reset
//   pix_en       out  one-Clk strobe; DrawX/DrawY advance on the edge where it is high
//   VGA_CLK      out  pixel clock, low in first half of the pixel period, high in second
//   VGA_HS       out  horizontal sync, active low
//   VGA_VS       out  vertical sync, active low
//   VGA_BLANK_N  out  low outside the visible area
//   VGA_SYNC_N   out  tied low
//   DrawX/DrawY  out  current pixel column / line
//   frame_start  out  one-Clk pulse after the scan wraps to (0,0)
//   frame_count  out  frames since reset, present only when VGA_FRAME_COUNT_EN is defined
module vga_scan_timer #(
  parameter int PIX_DIV = 2,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output logic       pix_en,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);
  localparam int DW = $clog2(PIX_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(PIX_DIV / 2);
  localparam logic [9:0] H_LAST = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_ON  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_OFF = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_ON  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_OFF = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] H_VIS_W = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W = 10'(V_VIS);
  logic [DW-1:0] div_q, div_d;
  logic [9:0] x_d, y_d;
  logic x_wrap, y_wrap, wrap;
  assign VGA_SYNC_N = 1'b0;
  // Every registered output is decoded from the next-state counters so it
  // lines up with the coordinates presented in the same cycle.
  always_comb begin
    div_d  = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    x_wrap = DrawX == H_LAST;
    y_wrap = DrawY == V_LAST;
    wrap   = pix_en && x_wrap && y_wrap;
    x_d    = pix_en ? (x_wrap ? 10'd0 : DrawX + 10'd1) : DrawX;
    y_d    = (pix_en && x_wrap) ? (y_wrap ? 10'd0 : DrawY + 10'd1) : DrawY;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q       <= '0;
      pix_en      <= 1'b0;
      VGA_CLK     <= 1'b0;
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      VGA_HS      <= 1'b1;
      VGA_VS      <= 1'b1;
      VGA_BLANK_N <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      div_q       <= div_d;
      pix_en      <= div_d == DIV_LAST;
      VGA_CLK     <= div_d >= DIV_HALF;
      DrawX       <= x_d;
      DrawY       <= y_d;
      VGA_HS      <= !(x_d >= HS_ON && x_d < HS_OFF);
      VGA_VS      <= !(y_d >= VS_ON && y_d < VS_OFF);
      VGA_BLANK_N <= x_d < H_VIS_W && y_d < V_VIS_W;
      frame_start <= wrap;
    end
  end
`ifdef VGA_FRAME_COUNT_EN
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) frame_count <= 16'd0;
    else if (wrap) frame_count <= frame_count + 16'd1;
  end
`endif
endmodule
